// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds hex operands from key codes, issues one ALU
// operation at a time over valid/ready and routes results to the display.
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_key_data,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic [WIDTH-1:0] i_res_data,
  input  logic             i_res_err,
  input  logic             i_res_valid,
  output logic             o_res_ready,
  output logic [WIDTH-1:0] o_display,
  output logic             o_error,
  output logic             o_busy
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_OP = 3'd1,
    ENTER_B  = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RES = 3'd4,
    SHOW_RES = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [1:0]       next_op_r;
  logic [CW-1:0]    digit_cnt_r;
  logic             chain_r;

  logic             key_acc_s;
  logic             is_digit_s;
  logic             is_ac_s;
  logic             is_op_s;
  logic             is_eq_s;
  logic             cnt_full_s;
  logic [1:0]       key_op_s;
  logic [WIDTH-1:0] digit_s;

  assign key_acc_s  = i_key_valid && o_key_ready;
  assign is_digit_s = ~i_key_data[4];
  assign is_ac_s    = (i_key_data == 5'h10);
  assign is_op_s    = (i_key_data >= 5'h11) && (i_key_data <= 5'h14);
  assign is_eq_s    = (i_key_data == 5'h15);
  // Operator code is the key code minus one, taken modulo 4.
  assign key_op_s   = i_key_data[1:0] + 2'b11;
  assign digit_s    = {{(WIDTH-4){1'b0}}, i_key_data[3:0]};
  assign cnt_full_s = (digit_cnt_r == CNT_MAX);

  assign o_key_ready = (state_r != ISSUE) && (state_r != WAIT_RES);
  assign o_alu_valid = (state_r == ISSUE);
  assign o_res_ready = (state_r == WAIT_RES);
  assign o_busy      = (state_r == ISSUE) || (state_r == WAIT_RES);
  assign o_error     = (state_r == ERROR);
  assign o_alu_a     = a_r;
  assign o_alu_b     = b_r;
  assign o_alu_op    = op_r;

  // Display source selected by the current state.
  always_comb begin
    o_display = {WIDTH{1'b0}};
    case (state_r)
      ENTER_A, ENTER_OP, SHOW_RES: o_display = a_r;
      ENTER_B, ISSUE, WAIT_RES:    o_display = b_r;
      default:                     o_display = {WIDTH{1'b0}};
    endcase
  end

  // Main sequencing FSM with operand and operator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ENTER_A;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 2'b00;
      next_op_r   <= 2'b00;
      digit_cnt_r <= {CW{1'b0}};
      chain_r     <= 1'b0;
    end else if (key_acc_s && is_ac_s) begin
      state_r     <= ENTER_A;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 2'b00;
      digit_cnt_r <= {CW{1'b0}};
      chain_r     <= 1'b0;
    end else begin
      case (state_r)
        ENTER_A: begin
          if (key_acc_s && is_digit_s && !cnt_full_s) begin
            a_r         <= {a_r[WIDTH-5:0], i_key_data[3:0]};
            digit_cnt_r <= digit_cnt_r + CNT_ONE;
          end else if (key_acc_s && is_op_s) begin
            op_r        <= key_op_s;
            b_r         <= {WIDTH{1'b0}};
            digit_cnt_r <= {CW{1'b0}};
            state_r     <= ENTER_OP;
          end
        end
        ENTER_OP: begin
          if (key_acc_s && is_digit_s) begin
            b_r         <= digit_s;
            digit_cnt_r <= CNT_ONE;
            state_r     <= ENTER_B;
          end else if (key_acc_s && is_op_s) begin
            op_r <= key_op_s;
          end
        end
        ENTER_B: begin
          if (key_acc_s && is_digit_s && !cnt_full_s) begin
            b_r         <= {b_r[WIDTH-5:0], i_key_data[3:0]};
            digit_cnt_r <= digit_cnt_r + CNT_ONE;
          end else if (key_acc_s && is_eq_s) begin
            chain_r <= 1'b0;
            state_r <= ISSUE;
          end else if (key_acc_s && is_op_s) begin
            chain_r   <= 1'b1;
            next_op_r <= key_op_s;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_alu_ready) begin
            state_r <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (i_res_valid) begin
            if (i_res_err) begin
              state_r <= ERROR;
            end else begin
              a_r         <= i_res_data;
              digit_cnt_r <= {CW{1'b0}};
              if (chain_r) begin
                op_r    <= next_op_r;
                b_r     <= {WIDTH{1'b0}};
                chain_r <= 1'b0;
                state_r <= ENTER_OP;
              end else begin
                state_r <= SHOW_RES;
              end
            end
          end
        end
        SHOW_RES: begin
          if (key_acc_s && is_digit_s) begin
            a_r         <= digit_s;
            digit_cnt_r <= CNT_ONE;
            state_r     <= ENTER_A;
          end else if (key_acc_s && is_op_s) begin
            op_r    <= key_op_s;
            b_r     <= {WIDTH{1'b0}};
            state_r <= ENTER_OP;
          end
        end
        ERROR: begin
          state_r <= ERROR;
        end
        default: begin
          state_r <= ENTER_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; the bench plays keypad and ALU.
module tb_calc_sequencer;

  localparam logic [4:0] K_AC  = 5'h10;
  localparam logic [4:0] K_ADD = 5'h11;
  localparam logic [4:0] K_SUB = 5'h12;
  localparam logic [4:0] K_MUL = 5'h13;
  localparam logic [4:0] K_DIV = 5'h14;
  localparam logic [4:0] K_EQ  = 5'h15;
  localparam logic [4:0] K_RSV = 5'h1F;

  logic        clk;
  logic        rst_n;
  logic [4:0]  i_key_data;
  logic        i_key_valid;
  logic        o_key_ready;
  logic [15:0] o_alu_a;
  logic [15:0] o_alu_b;
  logic [1:0]  o_alu_op;
  logic        o_alu_valid;
  logic        i_alu_ready;
  logic [15:0] i_res_data;
  logic        i_res_err;
  logic        i_res_valid;
  logic        o_res_ready;
  logic [15:0] o_display;
  logic        o_error;
  logic        o_busy;

  int n_checks = 0;
  int n_pass = 0;

  calc_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key_data (i_key_data),
    .i_key_valid(i_key_valid),
    .o_key_ready(o_key_ready),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .o_alu_valid(o_alu_valid),
    .i_alu_ready(i_alu_ready),
    .i_res_data (i_res_data),
    .i_res_err  (i_res_err),
    .i_res_valid(i_res_valid),
    .o_res_ready(o_res_ready),
    .o_display  (o_display),
    .o_error    (o_error),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic press(input logic [4:0] k);
    int n = 0;
    @(negedge clk);
    i_key_data  = k;
    i_key_valid = 1'b1;
    while (!o_key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("press_ready", o_key_ready, 1'b1);
    @(posedge clk);
    #1;
    i_key_valid = 1'b0;
  endtask

  // Called right after the terminating key: checks the request, accepts it
  // on its first cycle, then returns one result.
  task automatic serve(input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] eop,
                       input logic [15:0] res, input logic err);
    @(negedge clk);
    chk("issue_valid", o_alu_valid, 1'b1);
    chk("issue_keyrdy", o_key_ready, 1'b0);
    chk("issue_busy", o_busy, 1'b1);
    chk("issue_a", o_alu_a, ea);
    chk("issue_b", o_alu_b, eb);
    chk("issue_op", o_alu_op, eop);
    i_alu_ready = 1'b1;
    @(posedge clk);
    #1;
    i_alu_ready = 1'b0;
    @(negedge clk);
    chk("wait_valid", o_alu_valid, 1'b0);
    chk("wait_resrdy", o_res_ready, 1'b1);
    i_res_data  = res;
    i_res_err   = err;
    i_res_valid = 1'b1;
    @(posedge clk);
    #1;
    i_res_valid = 1'b0;
    i_res_err   = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_key_data  = 5'h00;
    i_key_valid = 1'b0;
    i_alu_ready = 1'b0;
    i_res_data  = 16'h0000;
    i_res_err   = 1'b0;
    i_res_valid = 1'b0;
    #12;
    chk("rst_keyrdy", o_key_ready, 1'b1);
    chk("rst_valid", o_alu_valid, 1'b0);
    chk("rst_resrdy", o_res_ready, 1'b0);
    chk("rst_error", o_error, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_disp", o_display, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Add: 12 + 3 = 15
    press(5'h01);
    press(5'h02);
    @(negedge clk);
    chk("add_dispA", o_display, 16'h0012);
    press(K_ADD);
    @(negedge clk);
    chk("add_dispop", o_display, 16'h0012);
    press(5'h03);
    @(negedge clk);
    chk("add_dispB", o_display, 16'h0003);
    press(K_EQ);
    serve(16'h0012, 16'h0003, 2'b00, 16'h0015, 1'b0);
    @(negedge clk);
    chk("add_result", o_display, 16'h0015);
    chk("add_keyrdy", o_key_ready, 1'b1);
    chk("add_busy", o_busy, 1'b0);
    chk("add_resrdy", o_res_ready, 1'b0);

    // Digit overflow and reserved code
    press(K_AC);
    for (int i = 1; i <= 5; i++) begin
      press(5'(i));
      @(negedge clk);
      chk("ovf_keyrdy", o_key_ready, 1'b1);
    end
    chk("ovf_disp", o_display, 16'h1234);
    press(K_RSV);
    @(negedge clk);
    chk("rsv_disp", o_display, 16'h1234);

    // Chaining: 6 x 2 - 4 = 8
    press(K_AC);
    press(5'h06);
    press(K_MUL);
    press(5'h02);
    press(K_SUB);
    serve(16'h0006, 16'h0002, 2'b10, 16'h000C, 1'b0);
    @(negedge clk);
    chk("chain_disp", o_display, 16'h000C);
    chk("chain_keyrdy", o_key_ready, 1'b1);
    chk("chain_op", o_alu_op, 2'b01);
    press(5'h04);
    press(K_EQ);
    serve(16'h000C, 16'h0004, 2'b01, 16'h0008, 1'b0);
    @(negedge clk);
    chk("chain_final", o_display, 16'h0008);

    // Error then AC
    press(K_AC);
    press(5'h05);
    press(K_DIV);
    press(5'h00);
    press(K_EQ);
    serve(16'h0005, 16'h0000, 2'b11, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("err_flag", o_error, 1'b1);
    chk("err_disp", o_display, 16'h0000);
    press(5'h07);
    @(negedge clk);
    chk("err_flag7", o_error, 1'b1);
    chk("err_disp7", o_display, 16'h0000);
    press(K_AC);
    @(negedge clk);
    chk("ac_flag", o_error, 1'b0);
    chk("ac_disp", o_display, 16'h0000);
    chk("ac_keyrdy", o_key_ready, 1'b1);

    // Backpressure: ALU holds off 10 cycles while key 7 is pending
    press(5'h01);
    press(K_ADD);
    press(5'h02);
    press(K_EQ);
    @(negedge clk);
    i_key_data  = 5'h07;
    i_key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", o_alu_valid, 1'b1);
      chk("bp_a", o_alu_a, 16'h0001);
      chk("bp_b", o_alu_b, 16'h0002);
      chk("bp_op", o_alu_op, 2'b00);
      chk("bp_keyrdy", o_key_ready, 1'b0);
      @(negedge clk);
    end
    i_alu_ready = 1'b1;
    @(posedge clk);
    #1;
    i_alu_ready = 1'b0;
    @(negedge clk);
    chk("bp_resrdy", o_res_ready, 1'b1);
    chk("bp_keyrdy_wait", o_key_ready, 1'b0);
    i_res_data  = 16'h0003;
    i_res_valid = 1'b1;
    @(posedge clk);
    #1;
    i_res_valid = 1'b0;
    @(negedge clk);
    chk("bp_result", o_display, 16'h0003);
    chk("bp_keyrdy_after", o_key_ready, 1'b1);
    @(posedge clk);
    #1;
    i_key_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_key", o_display, 16'h0007);

    // Reset during WAIT_RES
    press(K_AC);
    press(5'h01);
    press(K_ADD);
    press(5'h02);
    press(K_EQ);
    @(negedge clk);
    i_alu_ready = 1'b1;
    @(posedge clk);
    #1;
    i_alu_ready = 1'b0;
    @(negedge clk);
    chk("mid_resrdy", o_res_ready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resrdy", o_res_ready, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_disp", o_display, 16'h0000);
    chk("mid_rst_keyrdy", o_key_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    i_res_data  = 16'h0099;
    i_res_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_res_disp", o_display, 16'h0000);
    chk("late_res_busy", o_busy, 1'b0);
    chk("late_res_err", o_error, 1'b0);
    i_res_valid = 1'b0;
    press(5'h05);
    @(negedge clk);
    chk("post_rst_digit", o_display, 16'h0005);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Central controller of the tiny calculator. Consumes the 5-bit key stream from the keypad scanner, builds two hex operands digit by digit, and latches the operator. It issues one operation at a time to the arithmetic unit over a valid/ready handshake and collects the result. It also drives the value shown on the display.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, ≥ 8; max digits per operand = WIDTH/4
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_key_data  in  5  key code: 0_dddd = hex digit d; 10000 AC, 10001 +, 10010 −, 10011 ×, 10100 ÷, 10101 =; 10110–11111 reserved
- i_key_valid  in  1  key code valid
- o_key_ready  out  1  controller can accept a key
- o_alu_a, o_alu_b  out  WIDTH  operands
- o_alu_op  out  2  00 add, 01 sub, 10 mul, 11 div (op key code − 1)
- o_alu_valid  out  1  operation request valid
- i_alu_ready  in  1  arithmetic unit accepts request
- i_res_data  in  WIDTH  result
- i_res_err  in  1  result error (div by zero, overflow)
- i_res_valid  in  1  result valid
- o_res_ready  out  1  controller accepts result
- o_display  out  WIDTH  value to display
- o_error  out  1  error indicator
- o_busy  out  1  high in ISSUE or WAIT_RES

## Operation
- Registers:
  - A, B: WIDTH bits.
  - op: 2 bits.
  - digit_cnt: 0..WIDTH/4.
  - chain: 1-bit flag.
  - next_op: 2 bits.
- States: ENTER_A, ENTER_OP, ENTER_B, ISSUE, WAIT_RES, SHOW_RES, ERROR.
- A key is accepted on a cycle with i_key_valid && o_key_ready.
  - o_key_ready = 1 in ENTER_A, ENTER_OP, ENTER_B, SHOW_RES and ERROR.
  - o_key_ready = 0 in ISSUE and WAIT_RES.
- Reserved codes are accepted and discarded in every state. AC is handled identically in every state.
- Digit entry: the operand becomes {operand[WIDTH-5:0], d} and digit_cnt increments. If digit_cnt == WIDTH/4, the digit is accepted and dropped, with no change.
- AC (any accepting state): A = B = 0, op = 0, digit_cnt = 0, chain = 0, go to ENTER_A.
- ENTER_A:
  - digit → shift into A.
  - op key → op latched, B = 0, digit_cnt = 0, go to ENTER_OP.
  - = → ignored.
- ENTER_OP:
  - digit → B = d, digit_cnt = 1, go to ENTER_B.
  - op key → replaces op.
  - = → ignored.
- ENTER_B:
  - digit → shift into B.
  - = → chain = 0, go to ISSUE.
  - op key → chain = 1, next_op = key op, go to ISSUE.
- ISSUE:
  - Outputs: o_alu_valid = 1, o_alu_a = A, o_alu_b = B, o_alu_op = op.
  - These outputs must not change while o_alu_valid = 1.
  - On i_alu_ready → WAIT_RES.
- WAIT_RES: o_res_ready = 1. On i_res_valid:
  - If i_res_err → ERROR.
  - Else A = i_res_data and digit_cnt = 0.
  - If chain: op = next_op, B = 0, chain = 0, go to ENTER_OP.
  - Else go to SHOW_RES.
- SHOW_RES:
  - digit → A = d, digit_cnt = 1, go to ENTER_A (new calculation).
  - op key → op latched, B = 0, go to ENTER_OP (result is reused as A).
  - = → ignored.
- ERROR: every key except AC is accepted and ignored. o_error = 1.
- o_display:
  - A in ENTER_A, ENTER_OP and SHOW_RES.
  - B in ENTER_B, ISSUE and WAIT_RES.
  - 0 in ERROR.

## Timing
- Reset (async, immediate) values:
  - State ENTER_A; all data registers 0.
  - o_alu_valid = 0, o_res_ready = 0, o_error = 0, o_busy = 0, o_display = 0.
  - o_key_ready = 1 (decoded from state).
- All outputs are registered or decoded from registered state. There is no combinational path from i_key_valid, i_alu_ready or i_res_valid to any output.
- Key effects are visible the cycle after acceptance. One key is accepted per cycle, back-to-back.
- Terminating key (= or op in ENTER_B) accepted at cycle n:
  - o_alu_valid = 1 and o_key_ready = 0 from cycle n+1.
- i_alu_ready high on the first ISSUE cycle:
  - o_alu_valid drops after exactly one cycle.
  - o_res_ready = 1 from the following cycle.
- i_res_valid is ignored outside WAIT_RES. i_alu_ready is ignored outside ISSUE.
- Result accepted at cycle m: new A and the new state are visible at m+1, and o_key_ready = 1 at m+1.
- Reset asserted in ISSUE or WAIT_RES aborts the operation. The arithmetic unit's later result is ignored because o_res_ready = 0.

## Test plan
- **Add:** keys 1, 2, +, 3, = (WIDTH = 16).
  - o_alu_a = 0x0012, o_alu_b = 0x0003, o_alu_op = 00.
  - Return 0x0015 → o_display = 0x0015 in SHOW_RES.
- **Digit overflow:** keys 1, 2, 3, 4, 5.
  - A = 0x1234, the fifth digit is dropped.
  - o_key_ready stays 1 throughout.
- **Chaining:** keys 6, ×, 2, −, 4, =.
  - First request: A = 6, B = 2, op = 10.
  - Result 0x000C → ENTER_OP with op = 01.
  - Second request: A = 0x000C, B = 4; final display 0x0008.
- **Error and AC:** keys 5, ÷, 0, =; i_res_err = 1.
  - ERROR, o_error = 1, o_display = 0.
  - Digit 7 is accepted with no change.
  - AC → ENTER_A, o_error = 0, display 0.
- **Handshake backpressure:** i_alu_ready held low for 10 cycles during ISSUE.
  - o_alu_valid and operands stay stable, o_key_ready = 0.
  - Keys presented meanwhile stay pending and are accepted after the result.
- **Reset mid-operation:** rst_n low during WAIT_RES.
  - Immediate return to reset values.
  - A later i_res_valid = 1 has no effect.
